// File: rtl/neureka_package.sv
// Shared types and constants for the neureka weight-memory TCDM target.
package neureka_package;

  localparam int unsigned NEUREKA_MEM_BANDWIDTH_EXT = 256;
  localparam int unsigned WMEM_LATENCY_MAX          = 4;
  localparam int unsigned WMEM_RSP_FIFO_DEPTH       = 4;
  localparam int unsigned WMEM_OUTSTANDING_W        = $clog2(WMEM_RSP_FIFO_DEPTH + 1);
  localparam logic [15:0] WMEM_LFSR_SEED            = 16'hACE1;

  typedef struct packed {
    logic                          empty;
    logic                          full;
    logic [WMEM_OUTSTANDING_W-1:0] outstanding;
  } wmem_target_flags_t;

  // Fibonacci step for x^16 + x^14 + x^13 + x^11 + 1
  function automatic logic [15:0] wmem_lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/neureka_wmem_rsp_fifo.sv
// Fall-through response FIFO: a push into an empty FIFO is visible on the output in the same cycle.
module neureka_wmem_rsp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       valid_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rptr_q, wptr_q;
  logic [OW-1:0]    cnt_q;
  logic             pass, do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o     = (cnt_q == '0);
  assign full_o      = (cnt_q == OW'(DEPTH));
  assign occupancy_o = cnt_q;
  // Push and pop on an empty FIFO: entry flows straight through, nothing stored
  assign pass        = empty_o & push_i & pop_i;
  assign do_push     = push_i & ~pass & (~full_o | pop_i);
  assign do_pop      = pop_i & ~empty_o;
  assign valid_o     = push_i | ~empty_o;
  assign data_o      = empty_o ? (push_i ? data_i : '0) : mem_q[rptr_q];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_inc(wptr_q);
      if (do_pop)  rptr_q <= ptr_inc(rptr_q);
      cnt_q <= cnt_q + OW'(do_push) - OW'(do_pop);
    end
  end

  // Storage, not reset
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/neureka_wmem_tcdm_target.sv
// Weight-memory TCDM responder: byte-masked word array, fixed-latency read pipe, in-order
// fall-through response FIFO and credit-based grant.
// Optional: NEUREKA_WMEM_STALL_INJECT_EN adds an LFSR that randomly masks gnt_o.
module neureka_wmem_tcdm_target
  import neureka_package::*;
#(
  parameter int unsigned BW             = NEUREKA_MEM_BANDWIDTH_EXT,
  parameter int unsigned AW             = 32,
  parameter int unsigned IW             = 8,
  parameter int unsigned DEPTH          = 1024,
  parameter int unsigned LATENCY        = 2,
  parameter int unsigned RSP_FIFO_DEPTH = WMEM_RSP_FIFO_DEPTH
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               enable_i,
  input  logic               req_i,
  output logic               gnt_o,
  input  logic [AW-1:0]      add_i,
  input  logic               wen_i,
  input  logic [BW/8-1:0]    be_i,
  input  logic [BW-1:0]      data_i,
  input  logic [IW-1:0]      id_i,
  output logic               r_valid_o,
  input  logic               r_ready_i,
  output logic [BW-1:0]      r_data_o,
  output logic [IW-1:0]      r_id_o,
  output wmem_target_flags_t flags_o
);

  localparam int unsigned NB   = BW / 8;
  localparam int unsigned OFFW = $clog2(NB);
  localparam int unsigned IDXW = $clog2(DEPTH);
  localparam int unsigned CW   = $clog2(RSP_FIFO_DEPTH + 1);
  localparam int unsigned EW   = IW + BW;

  logic [BW-1:0]      mem_q [DEPTH];
  logic [IDXW-1:0]    idx;
  logic [BW-1:0]      rd_word;
  logic               accept, pop, stall;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [LATENCY-1:0] pipe_valid_q;
  logic [EW-1:0]      pipe_data_q [LATENCY];
  logic [EW-1:0]      fifo_data;
  logic               fifo_full, fifo_empty;
  logic [CW-1:0]      unused_fifo_occ;
  logic               unused_add;

  // Offset bits and bits above the word index are ignored, giving wrap modulo DEPTH
  assign idx        = add_i[OFFW +: IDXW];
  assign unused_add = ^add_i;
  assign rd_word    = wen_i ? mem_q[idx] : '0;

`ifdef NEUREKA_WMEM_STALL_INJECT_EN
  logic [15:0] lfsr_q;

  // Free-running stall LFSR, reseeded on reset and clear
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) lfsr_q <= WMEM_LFSR_SEED;
    else                    lfsr_q <= wmem_lfsr_next(lfsr_q);
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Credits cover pipe plus FIFO, so a pipe push always finds room; held off during reset
  assign gnt_o  = rst_ni & enable_i & ~clear_i & ~stall & (cnt_q < CW'(RSP_FIFO_DEPTH));
  assign accept = req_i & gnt_o;
  assign pop    = r_valid_o & r_ready_i;

  // Credit counter next state
  always_comb begin
    cnt_d = cnt_q;
    if (accept && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !accept) cnt_d = cnt_q - 1'b1;
  end

  // Credit counter register
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) cnt_q <= '0;
    else                    cnt_q <= cnt_d;
  end

  // Byte-masked write at the accept edge; array contents survive reset
  always_ff @(posedge clk_i) begin
    if (accept && !wen_i) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) mem_q[idx][8*b +: 8] <= data_i[8*b +: 8];
      end
    end
  end

  // Latency pipe valid bits; stage 0 is loaded at the accept edge
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      pipe_valid_q <= '0;
    end else begin
      pipe_valid_q[0] <= accept;
      for (int i = 1; i < LATENCY; i++) pipe_valid_q[i] <= pipe_valid_q[i-1];
    end
  end

  // Latency pipe payload: echoed ID and read word (zero for writes)
  always_ff @(posedge clk_i) begin
    pipe_data_q[0] <= {id_i, rd_word};
    for (int i = 1; i < LATENCY; i++) pipe_data_q[i] <= pipe_data_q[i-1];
  end

  neureka_wmem_rsp_fifo #(
    .DEPTH (RSP_FIFO_DEPTH),
    .WIDTH (EW)
  ) i_rsp_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .push_i      (pipe_valid_q[LATENCY-1]),
    .data_i      (pipe_data_q[LATENCY-1]),
    .pop_i       (pop),
    .data_o      (fifo_data),
    .valid_o     (r_valid_o),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .occupancy_o (unused_fifo_occ)
  );

  assign r_id_o   = fifo_data[EW-1 -: IW];
  assign r_data_o = fifo_data[BW-1:0];

  assign flags_o.empty       = fifo_empty;
  assign flags_o.full        = fifo_full;
  assign flags_o.outstanding = WMEM_OUTSTANDING_W'(cnt_q);

endmodule

// File: tb/tb_neureka_wmem_tcdm_target.sv
// Directed bench for neureka_wmem_tcdm_target plus a scoreboarded random stream.
module tb_neureka_wmem_tcdm_target;
  import neureka_package::*;

  localparam logic [255:0] PAT_A = {4{64'h0123_4567_89AB_CDEF}};
  localparam logic [255:0] PAT_B = {8{32'hCAFE_F00D}};

  logic               clk;
  logic               rst_ni, clear_i, enable_i, req_i, gnt_o, wen_i;
  logic [31:0]        add_i, be_i;
  logic [255:0]       data_i, r_data_o;
  logic [7:0]         id_i, r_id_o;
  logic               r_valid_o, r_ready_i;
  wmem_target_flags_t flags_o;

  int checks = 0;
  int failures = 0;

  neureka_wmem_tcdm_target #(
    .BW             (256),
    .AW             (32),
    .IW             (8),
    .DEPTH          (1024),
    .LATENCY        (2),
    .RSP_FIFO_DEPTH (4)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .clear_i   (clear_i),
    .enable_i  (enable_i),
    .req_i     (req_i),
    .gnt_o     (gnt_o),
    .add_i     (add_i),
    .wen_i     (wen_i),
    .be_i      (be_i),
    .data_i    (data_i),
    .id_i      (id_i),
    .r_valid_o (r_valid_o),
    .r_ready_i (r_ready_i),
    .r_data_o  (r_data_o),
    .r_id_o    (r_id_o),
    .flags_o   (flags_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request and hold it until granted (bounded); returns at posedge+1
  task automatic send(input logic wen, input logic [31:0] add, input logic [31:0] be,
                      input logic [255:0] data, input logic [7:0] id, output logic ok);
    ok = 1'b0;
    req_i = 1'b1; wen_i = wen; add_i = add; be_i = be; data_i = data; id_i = id;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (gnt_o) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (ok) begin @(posedge clk); #1; end
    req_i = 1'b0;
  endtask

  // Wait (bounded) for one response and consume it
  task automatic get_rsp(output logic got, output logic [7:0] id, output logic [255:0] data);
    got = 1'b0; id = '0; data = '0;
    r_ready_i = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (r_valid_o) begin got = 1'b1; id = r_id_o; data = r_data_o; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    r_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; enable_i = 1'b0; clear_i = 1'b0; req_i = 1'b0; wen_i = 1'b1;
    add_i = '0; be_i = '0; data_i = '0; id_i = '0; r_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({gnt_o, r_valid_o} !== 2'b00) begin
      failures++; $display("FAIL reset_handshake: gnt=%b r_valid=%b expected 0 0", gnt_o, r_valid_o);
    end
    checks++;
    if (r_data_o !== 256'd0 || r_id_o !== 8'd0) begin
      failures++; $display("FAIL reset_rsp: data=%h id=%h expected 0 0", r_data_o, r_id_o);
    end
    checks++;
    if (flags_o.outstanding !== 3'd0 || flags_o.empty !== 1'b1) begin
      failures++;
      $display("FAIL reset_flags: outstanding=%0d empty=%b expected 0 1", flags_o.outstanding,
               flags_o.empty);
    end
    @(posedge clk); #1;
    rst_ni = 1'b1; enable_i = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt_o !== 1'b1) begin failures++; $display("FAIL reset_gnt_after: gnt=%b expected 1", gnt_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    r_ready_i = 1'b1;
    req_i = 1'b1; wen_i = 1'b0; add_i = 32'h40; be_i = '1; data_i = PAT_A; id_i = 8'd1;
    @(negedge clk);
    checks++;
    if (gnt_o !== 1'b1) begin failures++; $display("FAIL wr_gnt: gnt=%b expected 1", gnt_o); end
    @(posedge clk); #1;
    wen_i = 1'b1; id_i = 8'd3; data_i = '0;
    @(negedge clk);
    checks++;
    if (r_valid_o !== 1'b0) begin failures++; $display("FAIL wr_early: r_valid=%b expected 0", r_valid_o); end
    @(posedge clk); #1;
    req_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({r_valid_o, r_id_o, r_data_o} !== {1'b1, 8'd1, 256'd0}) begin
      failures++;
      $display("FAIL wr_rsp: valid=%b id=%0d data=%h expected 1 1 0", r_valid_o, r_id_o, r_data_o);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({r_valid_o, r_id_o, r_data_o} !== {1'b1, 8'd3, PAT_A}) begin
      failures++;
      $display("FAIL rd_rsp: valid=%b id=%0d data=%h expected 1 3 %h", r_valid_o, r_id_o, r_data_o,
               PAT_A);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (r_valid_o !== 1'b0) begin failures++; $display("FAIL rd_done: r_valid=%b expected 0", r_valid_o); end
    @(posedge clk); #1;
    r_ready_i = 1'b0;
  endtask

  task automatic test_byte_enable();
    logic ok0, ok1, ok2, g;
    logic [7:0] id;
    logic [255:0] d;
    r_ready_i = 1'b0;
    send(1'b0, 32'h80, 32'hFFFF_FFFF, 256'd0, 8'd4, ok0);
    send(1'b0, 32'h80, 32'h0000_000F, {256{1'b1}}, 8'd5, ok1);
    send(1'b1, 32'h80, 32'h0, 256'd0, 8'd6, ok2);
    checks++;
    if (!(ok0 && ok1 && ok2)) begin failures++; $display("FAIL be_send: ok=%b%b%b expected 111", ok0, ok1, ok2); end
    get_rsp(g, id, d);
    checks++;
    if (!g || id !== 8'd4 || d !== 256'd0) begin
      failures++; $display("FAIL be_rsp0: got=%b id=%0d data=%h expected id=4 data=0", g, id, d);
    end
    get_rsp(g, id, d);
    checks++;
    if (!g || id !== 8'd5 || d !== 256'd0) begin
      failures++; $display("FAIL be_rsp1: got=%b id=%0d data=%h expected id=5 data=0", g, id, d);
    end
    get_rsp(g, id, d);
    checks++;
    if (!g || id !== 8'd6 || d !== 256'h0000_0000_FFFF_FFFF) begin
      failures++; $display("FAIL be_read: got=%b id=%0d data=%h expected id=6 data=ffffffff", g, id, d);
    end
  endtask

  task automatic test_backpressure();
    int grants;
    logic g, got;
    logic [7:0] id;
    logic [255:0] d;
    r_ready_i = 1'b0; grants = 0;
    req_i = 1'b1; wen_i = 1'b1; add_i = 32'h40; be_i = '0; data_i = '0; id_i = 8'd10;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      g = gnt_o;
      @(posedge clk); #1;
      if (g) begin grants++; id_i = id_i + 8'd1; end
    end
    checks++;
    if (grants != 4) begin failures++; $display("FAIL bp_grants: grants=%0d expected 4", grants); end
    @(negedge clk);
    checks++;
    if ({gnt_o, r_valid_o, r_id_o} !== {1'b0, 1'b1, 8'd10}) begin
      failures++;
      $display("FAIL bp_hold: gnt=%b valid=%b id=%0d expected 0 1 10", gnt_o, r_valid_o, r_id_o);
    end
    checks++;
    if (flags_o.full !== 1'b1 || flags_o.outstanding !== 3'd4) begin
      failures++;
      $display("FAIL bp_flags: full=%b outstanding=%0d expected 1 4", flags_o.full,
               flags_o.outstanding);
    end
    @(posedge clk); #1;
    r_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt_o !== 1'b0) begin failures++; $display("FAIL bp_pop_gnt0: gnt=%b expected 0", gnt_o); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({gnt_o, r_valid_o, r_id_o} !== {1'b1, 1'b1, 8'd11}) begin
      failures++;
      $display("FAIL bp_regrant: gnt=%b valid=%b id=%0d expected 1 1 11", gnt_o, r_valid_o, r_id_o);
    end
    @(posedge clk); #1;
    req_i = 1'b0;
    for (int k = 12; k <= 14; k++) begin
      get_rsp(got, id, d);
      checks++;
      if (!got || id !== 8'(k) || d !== PAT_A) begin
        failures++; $display("FAIL bp_order: got=%b id=%0d data=%h expected id=%0d", got, id, d, k);
      end
    end
  endtask

  task automatic test_clear();
    logic ok0, ok1, ok2;
    int seen;
    r_ready_i = 1'b0;
    send(1'b1, 32'h40, 32'h0, 256'd0, 8'd20, ok0);
    send(1'b1, 32'h40, 32'h0, 256'd0, 8'd21, ok1);
    send(1'b1, 32'h40, 32'h0, 256'd0, 8'd22, ok2);
    checks++;
    if (!(ok0 && ok1 && ok2)) begin failures++; $display("FAIL clr_send: ok=%b%b%b expected 111", ok0, ok1, ok2); end
    // A write offered together with clear must not land
    clear_i = 1'b1; req_i = 1'b1; wen_i = 1'b0; add_i = 32'h40; be_i = '1; data_i = '0; id_i = 8'd23;
    @(negedge clk);
    checks++;
    if ({gnt_o, r_valid_o} !== 2'b01) begin
      failures++; $display("FAIL clr_during: gnt=%b valid=%b expected 0 1", gnt_o, r_valid_o);
    end
    @(posedge clk); #1;
    clear_i = 1'b0; req_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({r_valid_o, gnt_o, flags_o.outstanding} !== {1'b0, 1'b1, 3'd0}) begin
      failures++;
      $display("FAIL clr_after: valid=%b gnt=%b outstanding=%0d expected 0 1 0", r_valid_o, gnt_o,
               flags_o.outstanding);
    end
    @(posedge clk); #1;
    r_ready_i = 1'b1; seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (r_valid_o) seen++;
      @(posedge clk); #1;
    end
    r_ready_i = 1'b0;
    checks++;
    if (seen != 0) begin failures++; $display("FAIL clr_ghost: responses=%0d expected 0", seen); end
  endtask

  task automatic test_enable();
    logic ok, got;
    int grants;
    logic [7:0] id;
    logic [255:0] d;
    r_ready_i = 1'b0;
    send(1'b1, 32'h40, 32'h0, 256'd0, 8'd40, ok);
    enable_i = 1'b0; req_i = 1'b1; wen_i = 1'b1; id_i = 8'd41; grants = 0;
    repeat (4) begin
      @(negedge clk);
      if (gnt_o) grants++;
      @(posedge clk); #1;
    end
    checks++;
    if (!ok || grants != 0) begin
      failures++; $display("FAIL en_gnt: ok=%b grants=%0d expected 1 0", ok, grants);
    end
    get_rsp(got, id, d);
    checks++;
    if (!got || id !== 8'd40 || d !== PAT_A) begin
      failures++; $display("FAIL en_drain: got=%b id=%0d data=%h expected id=40", got, id, d);
    end
    req_i = 1'b0; enable_i = 1'b1;
  endtask

  task automatic test_wrap();
    logic ok0, ok1, ok2, got;
    logic [7:0] id;
    logic [255:0] d;
    send(1'b1, 32'h8040, 32'h0, 256'd0, 8'd30, ok0);
    get_rsp(got, id, d);
    checks++;
    if (!ok0 || !got || id !== 8'd30 || d !== PAT_A) begin
      failures++; $display("FAIL wrap_read: got=%b id=%0d data=%h expected id=30 data=%h", got, id, d, PAT_A);
    end
    send(1'b0, 32'hFFF0_00C0, 32'hFFFF_FFFF, PAT_B, 8'd31, ok1);
    send(1'b1, 32'h0000_00C0, 32'h0, 256'd0, 8'd32, ok2);
    get_rsp(got, id, d);
    checks++;
    if (!ok1 || !got || id !== 8'd31 || d !== 256'd0) begin
      failures++; $display("FAIL wrap_wr_rsp: got=%b id=%0d data=%h expected id=31 data=0", got, id, d);
    end
    get_rsp(got, id, d);
    checks++;
    if (!ok2 || !got || id !== 8'd32 || d !== PAT_B) begin
      failures++; $display("FAIL wrap_alias: got=%b id=%0d data=%h expected id=32 data=%h", got, id, d, PAT_B);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic ok0, ok1, ok2, got;
    logic [7:0] id;
    logic [255:0] d;
    r_ready_i = 1'b0;
    send(1'b1, 32'h40, 32'h0, 256'd0, 8'd50, ok0);
    send(1'b1, 32'h40, 32'h0, 256'd0, 8'd51, ok1);
    rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(negedge clk);
    checks++;
    if ({r_valid_o, flags_o.outstanding} !== {1'b0, 3'd0}) begin
      failures++;
      $display("FAIL rst_burst: valid=%b outstanding=%0d expected 0 0", r_valid_o, flags_o.outstanding);
    end
    @(posedge clk); #1;
    send(1'b1, 32'h40, 32'h0, 256'd0, 8'd52, ok2);
    get_rsp(got, id, d);
    checks++;
    if (!(ok0 && ok1 && ok2) || !got || id !== 8'd52 || d !== PAT_A) begin
      failures++; $display("FAIL rst_keep: got=%b id=%0d data=%h expected id=52 data=%h", got, id, d, PAT_A);
    end
  endtask

  task automatic test_random_stream();
    logic [255:0] model [16];
    logic [263:0] exp_q [$];
    int sent, received;
    logic sender_done;
    sent = 0; received = 0; sender_done = 1'b0;
    r_ready_i = 1'b1;
    fork
      begin
        logic wen, ok;
        logic [3:0] w;
        logic [31:0] add, be;
        logic [255:0] data;
        for (int n = 0; n < 1000; n++) begin
          for (int k = 0; k < 8; k++) data[32*k +: 32] = $urandom;
          if (n < 16) begin
            wen = 1'b0; be = '1; w = 4'(n);
          end else begin
            wen = ($urandom_range(0, 1) == 1); be = $urandom; w = 4'($urandom_range(0, 15));
          end
          add = ($urandom & 32'hFFFF_8000) | (32'(w) << 5) | ($urandom & 32'h1F);
          send(wen, add, be, data, 8'(n), ok);
          checks++;
          if (!ok) begin
            failures++; $display("FAIL rand_send: request %0d not granted in bound", n);
          end else begin
            if (wen) begin
              exp_q.push_back({8'(n), model[w]});
            end else begin
              for (int b = 0; b < 32; b++) if (be[b]) model[w][8*b +: 8] = data[8*b +: 8];
              exp_q.push_back({8'(n), 256'd0});
            end
            sent++;
          end
        end
        sender_done = 1'b1;
      end
      begin
        logic [263:0] exp;
        for (int c = 0; c < 30000; c++) begin
          if (sender_done && received == sent) break;
          @(negedge clk);
          if (r_valid_o && r_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
              failures++; $display("FAIL rand_extra: unexpected response id=%0d", r_id_o);
            end else begin
              exp = exp_q.pop_front();
              if ({r_id_o, r_data_o} !== exp) begin
                failures++;
                $display("FAIL rand_rsp: id=%0d data=%h expected id=%0d data=%h", r_id_o, r_data_o,
                         exp[263:256], exp[255:0]);
              end
            end
            received++;
          end
          @(posedge clk); #1;
          r_ready_i = ($urandom_range(0, 3) != 0);
        end
      end
    join
    r_ready_i = 1'b0;
    checks++;
    if (received != sent || sent != 1000) begin
      failures++; $display("FAIL rand_count: sent=%0d received=%0d expected 1000 1000", sent, received);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_backpressure();
    test_clear();
    test_enable();
    test_wrap();
    test_reset_mid_burst();
    test_random_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
